// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default build parameters.
// The matching receiver imports this package as well.
package uart_pkg;

  localparam int unsigned FREQ_CLK_DFLT  = 100_000_000;
  localparam int unsigned DATA_WDTH_DFLT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..period_i-1 while enabled and strobes tick_o
// on the last count, restarting from 0 so each bit is exact with no drift.
module uart_baud_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == period_i - 32'd1);
    cnt_d  = cnt_q + 32'd1;
    if (!en_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style frame (start, DATA_WDTH bits LSB first, stop)
// with the bit period derived once per frame from the requested baud rate.
//
//   state | meaning
//   IDLE  | line high, counters held at 0, ready when baud rate is usable
//   START | line low for one bit period
//   DATA  | shift out latched bits LSB first, one bit period each
//   STOP  | line high for one bit period, then DONEo pulses in IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_CLK  = FREQ_CLK_DFLT,
  parameter int unsigned DATA_WDTH = DATA_WDTH_DFLT
) (
  input  logic                 CLKip,
  input  logic                 RSTi,
  input  logic                 VALIDi,
  input  logic [DATA_WDTH-1:0] DATAi,
  input  logic [31:0]          BAUD_RATEi,
  output logic                 READYo,
  output logic                 DONEo,
  output logic                 TXo
);

  localparam int IDX_W = $clog2(DATA_WDTH + 1);

  uart_state_e          state_q, state_d;
  logic [DATA_WDTH-1:0] data_q, data_d;
  logic [31:0]          period_q, period_d, period_calc;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 accept;

  // Guard the zero divisor so the ready qualifier never sees an undefined quotient.
  always_comb begin
    period_calc = (BAUD_RATEi == '0) ? '0 : 32'(FREQ_CLK) / BAUD_RATEi;
    READYo      = (state_q == IDLE) && (BAUD_RATEi != '0) && (period_calc >= 32'd2);
    accept      = VALIDi && READYo;
  end

  uart_baud_cnt u_baud_cnt (
    .clk      (CLKip),
    .rst      (RSTi),
    .en_i     (state_q != IDLE),
    .period_i (period_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    period_d = period_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) begin
          state_d  = START;
          data_d   = DATAi;
          period_d = period_calc;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_WDTH - 1)) begin
            state_d = STOP;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = data_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so TXo is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      state_q  <= IDLE;
      data_q   <= '0;
      period_q <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign TXo   = tx_q;
  assign DONEo = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx: per-cycle line model and a mid-bit
// sampling receiver model decode every frame.
module tb_uart_tx;

  localparam int unsigned FREQ = 100_000_000;
  localparam int          W    = 8;

  logic         CLKip = 1'b0;
  logic         RSTi;
  logic         VALIDi;
  logic [W-1:0] DATAi;
  logic [31:0]  BAUD_RATEi;
  logic         READYo;
  logic         DONEo;
  logic         TXo;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.FREQ_CLK(FREQ), .DATA_WDTH(W)) dut (
    .CLKip      (CLKip),
    .RSTi       (RSTi),
    .VALIDi     (VALIDi),
    .DATAi      (DATAi),
    .BAUD_RATEi (BAUD_RATEi),
    .READYo     (READYo),
    .DONEo      (DONEo),
    .TXo        (TXo)
  );

  always #5 CLKip = ~CLKip;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level k cycles after the acceptance edge (k = 1 is the first start cycle).
  function automatic logic exp_tx(input int k, input logic [W-1:0] d, input int p);
    if (k <= p) return 1'b0;
    if (k <= (W + 1) * p) return d[(k - p - 1) / p];
    return 1'b1;
  endfunction

  // Called at the negedge of cycle 1 of a frame; returns at the negedge of the
  // last checked cycle (the DONEo cycle when the frame is checked in full).
  task automatic check_frame(input logic [W-1:0] d, input int p, input int upto,
                             input int chg_at, input logic [31:0] chg_baud,
                             output logic [W-1:0] rx);
    int   len;
    logic line_q[$];
    len = (W + 2) * p;
    rx  = '0;
    for (int k = 1; k <= len + 1 && k <= upto; k++) begin
      if (k == chg_at) BAUD_RATEi = chg_baud;
      chk1("frame_tx",    TXo,    exp_tx(k, d, p));
      chk1("frame_done",  DONEo,  k == len + 1);
      chk1("frame_ready", READYo, k == len + 1);
      line_q.push_back(TXo);
      if (k < len + 1 && k < upto) @(negedge CLKip);
    end
    if (upto > len) begin
      chk1("rx_start_bit", line_q[p / 2 - 1], 1'b0);
      for (int i = 0; i < W; i++) rx[i] = line_q[p + i * p + p / 2 - 1];
      chk1("rx_stop_bit", line_q[(W + 1) * p + p / 2 - 1], 1'b1);
    end
  endtask

  task automatic launch(input logic [W-1:0] d);
    VALIDi = 1'b1;
    DATAi  = d;
    chk1("launch_ready", READYo, 1'b1);
    @(negedge CLKip);
    VALIDi = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rx, d, d2;
    logic [31:0]  bad_baud [2];
    int           rx_ok;
    int           gap;

    RSTi       = 1'b1;
    VALIDi     = 1'b0;
    DATAi      = '0;
    BAUD_RATEi = 32'd10_000_000;

    // Reset state; VALIDi during reset must not start a frame.
    repeat (2) @(negedge CLKip);
    VALIDi = 1'b1;
    DATAi  = 8'h5A;
    @(negedge CLKip);
    chk1("rst_tx", TXo, 1'b1);
    chk1("rst_done", DONEo, 1'b0);
    RSTi   = 1'b0;
    VALIDi = 1'b0;
    @(negedge CLKip);
    chk1("post_rst_tx", TXo, 1'b1);
    chk1("post_rst_ready", READYo, 1'b1);
    chk1("post_rst_done", DONEo, 1'b0);

    // Single frame 0xA5, P=10
    launch(8'hA5);
    check_frame(8'hA5, 10, 1000, 0, '0, rx);
    chk32("single_rx", 32'(rx), 32'h0000_00A5);
    @(negedge CLKip);
    chk1("done_one_cycle", DONEo, 1'b0);
    chk1("idle_tx", TXo, 1'b1);

    // Back-to-back with VALIDi held high: 0x00 then 0xFF
    VALIDi = 1'b1;
    DATAi  = 8'h00;
    @(negedge CLKip);
    DATAi = 8'hFF;
    check_frame(8'h00, 10, 1000, 0, '0, rx);
    chk32("b2b_rx0", 32'(rx), 32'h0);
    @(negedge CLKip);
    VALIDi = 1'b0;
    check_frame(8'hFF, 10, 1000, 0, '0, rx);
    chk32("b2b_rx1", 32'(rx), 32'hFF);
    @(negedge CLKip);

    // Reset at cycle 45 of a frame
    d = W'($urandom);
    launch(d);
    check_frame(d, 10, 45, 0, '0, rx);
    RSTi = 1'b1;
    @(negedge CLKip);
    chk1("midrst_tx", TXo, 1'b1);
    chk1("midrst_done", DONEo, 1'b0);
    RSTi = 1'b0;
    @(negedge CLKip);
    chk1("midrst_ready", READYo, 1'b1);
    for (int i = 0; i < 120; i++) begin
      chk1("midrst_no_done", DONEo, 1'b0);
      chk1("midrst_idle_tx", TXo, 1'b1);
      @(negedge CLKip);
    end

    // Unusable baud rates: divide by zero and P=1
    bad_baud[0] = 32'd0;
    bad_baud[1] = 32'd80_000_000;
    for (int b = 0; b < 2; b++) begin
      BAUD_RATEi = bad_baud[b];
      VALIDi     = 1'b1;
      DATAi      = 8'h3C;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLKip);
        chk1("badbaud_ready", READYo, 1'b0);
        chk1("badbaud_tx", TXo, 1'b1);
        chk1("badbaud_done", DONEo, 1'b0);
      end
      VALIDi = 1'b0;
    end

    // Smallest legal period P=2
    BAUD_RATEi = 32'd50_000_000;
    @(negedge CLKip);
    d = W'($urandom);
    launch(d);
    check_frame(d, 2, 1000, 0, '0, rx);
    chk32("p2_rx", 32'(rx), 32'(d));
    BAUD_RATEi = 32'd10_000_000;
    @(negedge CLKip);

    // Baud change during DATA only affects the next frame
    d  = W'($urandom);
    d2 = W'($urandom);
    launch(d);
    check_frame(d, 10, 1000, 35, 32'd5_000_000, rx);
    chk32("bchg_rx0", 32'(rx), 32'(d));
    @(negedge CLKip);
    launch(d2);
    check_frame(d2, 20, 1000, 0, '0, rx);
    chk32("bchg_rx1", 32'(rx), 32'(d2));
    BAUD_RATEi = 32'd10_000_000;
    @(negedge CLKip);

    // Loopback: 256 random bytes through the receiver model, random idle gaps
    rx_ok = 0;
    for (int n = 0; n < 256; n++) begin
      d   = W'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge CLKip);
        chk1("loop_gap_tx", TXo, 1'b1);
      end
      launch(d);
      check_frame(d, 10, 1000, 0, '0, rx);
      chk32("loop_rx", 32'(rx), 32'(d));
      if (rx === d) rx_ok++;
    end
    chk32("loop_count", 32'(rx_ok), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter FREQ_CLK, default 100_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter DATA_WDTH, default 8, meaning data bits per frame.
REQ-003 The block SHALL have one clock and a synchronous active-high reset. The port list SHALL be as follows, one port per line:
- CLKip  input  1  clock; all logic on rising edge.
- RSTi  input  1  synchronous active-high reset.
- VALIDi  input  1  request to send DATAi.
- DATAi  input  DATA_WDTH  byte to transmit.
- BAUD_RATEi  input  32  baud rate in bit/s.
- READYo  output  1  block can accept a frame this cycle.
- DONEo  output  1  one-cycle pulse at frame completion.
- TXo  output  1  serial line; idles high.

Function
REQ-004 Bit period P SHALL be FREQ_CLK / BAUD_RATEi, integer division truncating, computed as 32-bit unsigned.
REQ-005 P SHALL be captured into a register at frame acceptance; BAUD_RATEi changes mid-frame SHALL NOT affect the current frame.
REQ-006 The FSM SHALL have states IDLE, START, DATA, STOP, encoded as a 2-bit enum.
REQ-007 READYo SHALL be high only in IDLE, and only when BAUD_RATEi != 0 and FREQ_CLK / BAUD_RATEi >= 2.
REQ-008 A frame SHALL be accepted on the rising edge where VALIDi and READYo are both high. On acceptance, DATAi and P SHALL be latched and the FSM SHALL move IDLE->START.
REQ-009 VALIDi SHALL be ignored while READYo is low. There SHALL be no queueing.
REQ-010 TXo SHALL be registered and SHALL go low in the first cycle after the acceptance edge.
REQ-011 START SHALL drive TXo=0 for exactly P cycles, then the FSM SHALL move to DATA.
REQ-012 DATA SHALL drive the latched bits LSB first, each for exactly P cycles. The bit index SHALL run 0..DATA_WDTH-1; after the last bit the FSM SHALL move to STOP.
REQ-013 STOP SHALL drive TXo=1 for exactly P cycles, then the FSM SHALL return to IDLE.
REQ-014 Frame length on TXo SHALL be exactly (DATA_WDTH+2)*P cycles.
REQ-015 DONEo SHALL pulse high for exactly one cycle: the first IDLE cycle after STOP, the same cycle READYo returns high.
REQ-016 The minimum gap between frames SHALL be one idle-high cycle, beyond the stop bit, for back-to-back frames.
REQ-017 The bit-period counter SHALL count 0..P-1 and reset to 0 on every bit boundary, with no cumulative drift.
REQ-018 The bit index SHALL be $clog2(DATA_WDTH+1) bits wide and SHALL reset to 0 on entry to START.
REQ-019 In IDLE, TXo SHALL be 1 and the counters SHALL be held at 0.
REQ-020 Any illegal state encoding SHALL return the FSM to IDLE on the next cycle with TXo=1.

Reset
REQ-021 RSTi SHALL be sampled on the rising edge of CLKip; no asynchronous path SHALL exist.
REQ-022 Reset values SHALL be: FSM=IDLE, TXo=1, DONEo=0, counters=0, latched data=0. READYo SHALL then follow REQ-007.
REQ-023 Reset mid-frame SHALL abort the frame: TXo SHALL be 1 in the first cycle after reset is sampled, and no DONEo SHALL be issued.
REQ-024 While RSTi is high, VALIDi SHALL NOT be accepted.

Structure
REQ-025 The state enum, and the FREQ_CLK and DATA_WDTH defaults, SHALL live in shared package uart_pkg, also imported by the receiver.
REQ-026 The bit-period counter SHALL be a sub-module uart_baud_cnt with ports: clock, reset, enable, period in, and end-of-bit strobe out.
REQ-027 The divider SHALL NOT be instantiated per bit. One division result SHALL be registered per frame.

Verification
All scenarios use FREQ_CLK=100_000_000 and BAUD_RATEi=10_000_000, so P=10.
REQ-028 Single frame: send DATAi=8'hA5 -> TXo low for cycles 1-10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles. DONEo SHALL pulse at cycle 101 after acceptance.
REQ-029 Back-to-back: hold VALIDi high with 8'h00 then 8'hFF -> second start bit begins exactly 1 cycle after the first DONEo. Each frame SHALL be 100 cycles.
REQ-030 Mid-frame reset: assert RSTi at cycle 45 of a frame -> TXo=1 next cycle, no DONEo, READYo=1 after release.
REQ-031 Invalid baud rate: BAUD_RATEi=0, or BAUD_RATEi=80_000_000 (P=1) -> READYo=0, VALIDi ignored, TXo stays 1.
REQ-032 Mid-frame baud change: change BAUD_RATEi to 5_000_000 during DATA -> current frame keeps 10-cycle bits; the next frame uses 20-cycle bits.
REQ-033 Loopback: connect TXo to the uart_rx receive input, send 256 random bytes -> each received byte equals the sent byte, with no framing loss.
